// File: rtl/trace_cmd_issuer_pkg.sv
// Shared definitions for the trace command issuer: command codes, FSM states, entry width.
// TRACE_AUTO_PRINT_EN adds the PRINT state used for the closing print command.
package trace_cmd_issuer_pkg;

    localparam int ENTRY_W = 36;

    localparam logic [3:0] CMD_CODE0      = 4'd0;
    localparam logic [3:0] CMD_CODE1      = 4'd1;
    localparam logic [3:0] CMD_INST_FETCH = 4'd2;
    localparam logic [3:0] CMD_INVALIDATE = 4'd3;
    localparam logic [3:0] CMD_CODE4      = 4'd4;
    localparam logic [3:0] CMD_RESET      = 4'd8;
    localparam logic [3:0] CMD_PRINT      = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
`ifdef TRACE_AUTO_PRINT_EN
        ST_PRINT = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_legal_n(input logic [3:0] n);
        return n inside {CMD_CODE0, CMD_CODE1, CMD_INST_FETCH, CMD_INVALIDATE,
                         CMD_CODE4, CMD_RESET, CMD_PRINT};
    endfunction

endpackage

// File: rtl/trace_cmd_issuer_mem.sv
// Trace entry store: one write port, registered read port.
// A read of the address being written returns the new data (write-first).
module trace_cmd_issuer_mem
    import trace_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int PTR_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        // Lets an entry written in the same cycle as start be replayed first.
        if (we && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_cmd_issuer.sv
// Replays a loaded {n, address} trace to the cache over valid/ready, skipping illegal n codes.
// TRACE_AUTO_PRINT_EN appends a print command (n=9, addr=0) after the last entry.
module trace_cmd_issuer
    import trace_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int PTR_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_we,
    input  logic [ENTRY_W-1:0] load_data,
    input  logic               start,
    input  logic               clear,
    output logic               cmd_valid,
    output logic [3:0]         cmd_n,
    output logic [31:0]        cmd_addr,
    input  logic               cmd_ready,
    output logic               load_full,
    output logic               busy,
    output logic               done,
    output logic [31:0]        issued_cnt,
    output logic [15:0]        err_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
`ifdef TRACE_AUTO_PRINT_EN
    localparam state_t END_STATE = ST_PRINT;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t             state, state_d;
    logic [PTR_W:0]     count, rd_ptr, rd_ptr_d, rd_next;
    logic [ENTRY_W-1:0] rd_data;
    logic               wr_en, more, err_inc, iss_inc, cmd_load, clr_all;

    assign load_full = (count == FULL_CNT);
    assign wr_en     = !reset && (state == ST_IDLE) && load_we && !load_full;
    assign rd_next   = rd_ptr + 1'b1;
    assign more      = (rd_next < count);

    trace_cmd_issuer_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (count[PTR_W-1:0]),
        .wr_data (load_data),
        .rd_addr (rd_ptr_d[PTR_W-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state;
        rd_ptr_d = rd_ptr;
        err_inc  = 1'b0;
        iss_inc  = 1'b0;
        cmd_load = 1'b0;
        clr_all  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    rd_ptr_d = '0;
                    state_d  = (count != '0 || wr_en) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (is_legal_n(rd_data[35:32])) begin
                    cmd_load = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    err_inc  = 1'b1;
                    rd_ptr_d = rd_next;
                    state_d  = more ? ST_FETCH : END_STATE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    iss_inc  = 1'b1;
                    rd_ptr_d = rd_next;
                    state_d  = more ? ST_FETCH : END_STATE;
                end
            end
`ifdef TRACE_AUTO_PRINT_EN
            ST_PRINT: begin
                if (cmd_ready) begin
                    iss_inc = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (clear) begin
                    clr_all  = 1'b1;
                    rd_ptr_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            cmd_n      <= '0;
            cmd_addr   <= '0;
            issued_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            state  <= state_d;
            rd_ptr <= rd_ptr_d;
            if (clr_all)    count <= '0;
            else if (wr_en) count <= count + 1'b1;
            if (cmd_load) begin
                cmd_n    <= rd_data[35:32];
                cmd_addr <= rd_data[31:0];
            end
`ifdef TRACE_AUTO_PRINT_EN
            if (state != ST_PRINT && state_d == ST_PRINT) begin
                cmd_n    <= CMD_PRINT;
                cmd_addr <= '0;
            end
`endif
            if (clr_all)      issued_cnt <= '0;
            else if (iss_inc) issued_cnt <= issued_cnt + 32'd1;
            if (clr_all)                              err_cnt <= '0;
            else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef TRACE_AUTO_PRINT_EN
    assign cmd_valid = (state == ST_ISSUE) || (state == ST_PRINT);
    assign busy      = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_PRINT);
`else
    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state == ST_FETCH) || (state == ST_ISSUE);
`endif
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_trace_cmd_issuer.sv
// Directed self-checking bench for trace_cmd_issuer; follows TRACE_AUTO_PRINT_EN if defined.
module tb_trace_cmd_issuer;

`ifdef TRACE_AUTO_PRINT_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_we = 1'b0;
    logic [35:0] load_data = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_n;
    logic [31:0] cmd_addr;
    logic        load_full, busy, done;
    logic [31:0] issued_cnt;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] q[$];
    logic [3:0]  legal_tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

    trace_cmd_issuer dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_data(load_data),
        .start(start), .clear(clear), .cmd_valid(cmd_valid), .cmd_n(cmd_n),
        .cmd_addr(cmd_addr), .cmd_ready(cmd_ready), .load_full(load_full),
        .busy(busy), .done(done), .issued_cnt(issued_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Record every accepted command as the cache would see it.
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) q.push_back({cmd_n, cmd_addr});
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic load_entry(input logic [3:0] n, input logic [31:0] addr);
        load_we = 1'b1;
        load_data = {n, addr};
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        for (k = 0; k < budget && !done; k++) @(negedge clk);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cmd_valid, cmd_n, cmd_addr, load_full, busy, done} !== '0 ||
            issued_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b n=%0d addr=%h full=%0b busy=%0b done=%0b iss=%0d err=%0d, required all 0",
                     cmd_valid, cmd_n, cmd_addr, load_full, busy, done, issued_cnt, err_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cmd_ready = 1'b1;
        load_entry(4'd2, 32'h0040_0040);
        load_entry(4'd3, 32'h0040_0040);
        pulse_start();
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fetch_cycle: valid=%0b busy=%0b, required valid=0 busy=1", cmd_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_n !== 4'd2 || cmd_addr !== 32'h0040_0040) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%0b n=%0d addr=%h, required 1 2 00400040", cmd_valid, cmd_n, cmd_addr);
        end
        wait_done(20, "basic");
        n_checks++;
        if (q.size() != 2 + PX || q[0] !== {4'd2, 32'h0040_0040} || q[1] !== {4'd3, 32'h0040_0040}) begin
            n_fail++;
            $display("FAIL basic_order: size=%0d q0=%h q1=%h, required %0d 200400040 300400040",
                     q.size(), q[0], q[1], 2 + PX);
        end
        n_checks++;
        if (issued_cnt !== 32'(2 + PX) || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_counts: iss=%0d done=%0b busy=%0b, required %0d 1 0", issued_cnt, done, busy, 2 + PX);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (done !== 1'b0 || issued_cnt !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: done=%0b iss=%0d busy=%0b, required 0 0 0", done, issued_cnt, busy);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        cmd_ready = 1'b1;
        load_entry(4'd2, 32'h1000);
        load_entry(4'd12, 32'h2000);
        load_entry(4'd8, 32'h0);
        pulse_start();
        wait_done(30, "illegal");
        n_checks++;
        if (q.size() != 2 + PX || q[0] !== {4'd2, 32'h1000} || q[1] !== {4'd8, 32'h0}) begin
            n_fail++;
            $display("FAIL illegal_filter: size=%0d q0=%h q1=%h, required %0d 200001000 800000000",
                     q.size(), q[0], q[1], 2 + PX);
        end
        n_checks++;
        if (err_cnt !== 16'd1 || issued_cnt !== 32'(2 + PX)) begin
            n_fail++;
            $display("FAIL illegal_counts: err=%0d iss=%0d, required 1 %0d", err_cnt, issued_cnt, 2 + PX);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        cmd_ready = 1'b0;
        load_entry(4'd4, 32'hABCD_1234);
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid !== 1'b1 || cmd_n !== 4'd4 || cmd_addr !== 32'hABCD_1234 || issued_cnt !== 32'd0)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles, last valid=%0b n=%0d addr=%h iss=%0d, required 0",
                     bad, cmd_valid, cmd_n, cmd_addr, issued_cnt);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (issued_cnt !== 32'd1 || cmd_valid !== PX[0]) begin
            n_fail++;
            $display("FAIL stall_release: iss=%0d valid=%0b, required 1 %0d", issued_cnt, cmd_valid, PX);
        end
        wait_done(10, "stall");
        n_checks++;
        if (issued_cnt !== 32'(1 + PX) || q.size() != 1 + PX) begin
            n_fail++;
            $display("FAIL stall_single_issue: iss=%0d size=%0d, required %0d", issued_cnt, q.size(), 1 + PX);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        do_reset();
        cmd_ready = 1'b1;
        load_we = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            load_data = {legal_tbl[i % 7], 32'(i)};
            @(negedge clk);
            if (i == 1022) begin
                n_checks++;
                if (load_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: load_full=%0b after 1023 writes, required 0", load_full);
                end
            end
            if (i == 1023) begin
                n_checks++;
                if (load_full !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_set: load_full=%0b after 1024 writes, required 1", load_full);
                end
            end
        end
        load_we = 1'b0;
        pulse_start();
        wait_done(3000, "full");
        n_checks++;
        if (q.size() != 1024 + PX || issued_cnt !== 32'(1024 + PX)) begin
            n_fail++;
            $display("FAIL full_replay_count: size=%0d iss=%0d, required %0d", q.size(), issued_cnt, 1024 + PX);
        end
        for (int i = 0; i < 1024 && i < q.size(); i++)
            if (q[i] !== {legal_tbl[i % 7], 32'(i)}) bad++;
        n_checks++;
        if (bad != 0 || q.size() < 1024) begin
            n_fail++;
            $display("FAIL full_replay_data: %0d wrong entries, size=%0d, required 0 wrong", bad, q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_ready = 1'b0;
        load_entry(4'd3, 32'h77);
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: valid=%0b, required 1", cmd_valid);
        end
        reset = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issued_cnt !== 32'd0 ||
            err_cnt !== 16'd0 || load_full !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset: valid=%0b busy=%0b done=%0b iss=%0d err=%0d size=%0d, required all 0",
                     cmd_valid, busy, done, issued_cnt, err_cnt, q.size());
        end
        pulse_start();
        n_checks++;
        if (done !== 1'b1 || issued_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL empty_start: done=%0b iss=%0d, required 1 0", done, issued_cnt);
        end
    endtask

    task automatic test_start_with_load();
        do_reset();
        cmd_ready = 1'b1;
        load_we = 1'b1;
        load_data = {4'd1, 32'h55};
        start = 1'b1;
        @(negedge clk);
        load_we = 1'b0;
        start = 1'b0;
        wait_done(20, "start_load");
        n_checks++;
        if (q.size() != 1 + PX || q[0] !== {4'd1, 32'h55} || issued_cnt !== 32'(1 + PX)) begin
            n_fail++;
            $display("FAIL start_with_load: size=%0d q0=%h iss=%0d, required %0d 100000055 %0d",
                     q.size(), q[0], issued_cnt, 1 + PX, 1 + PX);
        end
`ifdef TRACE_AUTO_PRINT_EN
        n_checks++;
        if (q[1] !== {4'd9, 32'h0}) begin
            n_fail++;
            $display("FAIL auto_print: q1=%h, required 900000000", q[1]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_stall();
        test_full();
        test_reset_mid();
        test_start_with_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_cmd_issuer.md
Name: trace_cmd_issuer

Overview:
Initiator side of the trace-command interface, the `n` / `add_in` pair that the instruction and data caches consume. It buffers a loaded trace of {n, address} entries in an internal memory. On start, it replays the entries one at a time over a valid/ready handshake. Commands with illegal n codes are filtered out and counted. It sits between the testbench or trace loader and the cache array.

Parameters:
- DEPTH, 1024, number of trace entries held.
- PTR_W, 10, pointer width; must equal log2(DEPTH).
- ENTRY_W, 36, entry width: {n[3:0], addr[31:0]}.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_we  in  1  write one trace entry (honoured only in IDLE).
- load_data  in  36  entry to write; [35:32]=n, [31:0]=address.
- start  in  1  single-cycle pulse that begins replay (honoured only in IDLE).
- clear  in  1  single-cycle pulse; DONE -> IDLE, empties the buffer.
- cmd_valid  out  1  command presented.
- cmd_n  out  4  command code to the cache `n` input.
- cmd_addr  out  32  address to the cache `add_in` input.
- cmd_ready  in  1  cache accepts the command this cycle.
- load_full  out  1  buffer holds DEPTH entries.
- busy  out  1  state is FETCH, ISSUE or PRINT.
- done  out  1  state is DONE.
- issued_cnt  out  32  commands accepted by the cache.
- err_cnt  out  16  entries skipped for an illegal n.

Behaviour:
- Reset (synchronous, priority over all inputs):
  - state=IDLE; wr_ptr=0, rd_ptr=0, count=0.
  - All outputs 0: cmd_valid, cmd_n, cmd_addr, load_full, busy, done, issued_cnt, err_cnt.
  - A reset mid-replay drops the presented command immediately; no partial handshake completes.
- Legal n codes: 0, 1, 2, 3, 4, 8, 9. Codes 5–7 and 10–15 are illegal.
- Load (IDLE only):
  - load_we with count<DEPTH: mem[wr_ptr]<=load_data; wr_ptr and count increment.
  - count==DEPTH: write ignored; load_full=1.
  - load_we in any other state: ignored.
- States: IDLE, FETCH, ISSUE, PRINT, DONE.
  - IDLE: start with count>0 -> FETCH, rd_ptr=0. Start with count==0 -> DONE. Start outside IDLE is ignored.
  - FETCH: registered read of mem[rd_ptr], one cycle.
    - Legal n: load cmd_n/cmd_addr, -> ISSUE.
    - Illegal n: err_cnt+1 (saturating at 0xFFFF). rd_ptr+1, then -> FETCH if entries remain, else -> end-of-trace.
  - ISSUE: cmd_valid=1; cmd_n and cmd_addr are held stable until cmd_ready.
    - On cmd_valid&cmd_ready: issued_cnt+1 (wraps modulo 2^32). cmd_valid deasserts next cycle; rd_ptr+1.
    - Then -> FETCH if rd_ptr+1<count, else -> end-of-trace.
  - End-of-trace: -> PRINT if the optional feature is enabled, else -> DONE.
  - DONE: done=1; outputs idle.
    - clear -> IDLE with wr_ptr=0, count=0, load_full=0, issued_cnt=0, err_cnt=0.
    - clear in any other state: ignored.
- Timing:
  - Latency from start to first cmd_valid is 2 cycles (start at t, FETCH at t+1, ISSUE at t+2).
  - Peak throughput is one command per 2 cycles.
  - cmd_ready held high indefinitely causes no extra issue.
  - cmd_ready while cmd_valid=0 is ignored.
- Simultaneous start and load_we in IDLE: the write lands first, and replay includes that entry.
- The entry at index DEPTH-1 is replayed normally; rd_ptr never wraps during a replay.

Optional Feature:
- Macro: TRACE_AUTO_PRINT_EN.
- Defined: after the last entry, the PRINT state presents cmd_n=9, cmd_addr=0 with the same handshake. issued_cnt increments on acceptance, then -> DONE.
- Undefined: the PRINT state is not compiled; end-of-trace goes straight to DONE.

Decomposition:
- Shared package holds:
  - Command code constants: RESET=8, INVALIDATE=3, INST_FETCH=2, PRINT=9, plus the remaining legal codes 0, 1, 4.
  - State enum.
  - ENTRY_W.
  - The legal-code check function.
- One sub-module, trace_mem: single-port-write, registered-read DEPTH x ENTRY_W memory.

Test Plan:
- Load {2,0x00400040}, {3,0x00400040}; start; cmd_ready=1 -> cmd_valid first rises 2 cycles after start; two commands issued in order; issued_cnt=2; done=1.
- Load {2,0x1000}, {12,0x2000}, {8,0} -> cache sees n=2 then n=8 only; err_cnt=1; issued_cnt=2.
- Hold cmd_ready=0 for 5 cycles in ISSUE -> cmd_valid, cmd_n and cmd_addr stay constant; issued_cnt unchanged until cmd_ready=1.
- Write 1025 entries with DEPTH=1024 -> load_full=1 after the 1024th write; the 1025th is dropped; replay issues 1024 commands.
- Assert reset during ISSUE -> next cycle cmd_valid=0, state IDLE, all counters 0. Start with an empty buffer -> done=1 one cycle later.
- With TRACE_AUTO_PRINT_EN, a 1-entry trace -> two commands issued; the second has n=9, addr=0; issued_cnt=2.
